// File: rtl/smag2fp_pkg.sv
// Shared widths, fp field slices and FSM state encoding for the smag <-> fp converters.
package smag2fp_pkg;
  localparam int MAG_W      = 7;
  localparam int EXP_W      = 4;
  localparam int FRAC_W     = MAG_W + 1;
  localparam int FP_W       = 1 + EXP_W + FRAC_W;
  localparam int FP_SIGN    = FP_W - 1;
  localparam int FP_EXP_HI  = FP_W - 2;
  localparam int FP_EXP_LO  = FRAC_W;
  localparam int FP_FRAC_HI = FRAC_W - 1;
  localparam int FP_FRAC_LO = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NORM = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [FP_W-1:0] pack_fp(input logic s,
                                              input logic [EXP_W-1:0] e,
                                              input logic [FRAC_W-1:0] f);
    return {s, e, f};
  endfunction
endpackage

// File: rtl/smag2fp_if.sv
// Start/ready/done handshake and data bus of the smag-to-fp converter.
interface smag2fp_if;
  import smag2fp_pkg::*;
  logic            i_start;
  logic [MAG_W:0]  i_smag;
  logic            o_ready;
  logic            o_done;
  logic [FP_W-1:0] o_fp;

  modport master (output i_start, i_smag, input o_ready, o_done, o_fp);
  modport slave  (input i_start, i_smag, output o_ready, o_done, o_fp);
endinterface

// File: rtl/smag2fp.sv
// Sign-magnitude to {sign, exp, frac} float, normalised one left shift per clock.
// Build option SMAG2FP_NEG_ZERO_EN keeps the sign of a zero magnitude (-0 preserved).
//
// state  | meaning
// S_IDLE | ready, waiting for i_start
// S_NORM | shifting frac left until frac[7]=1 or frac=0
// S_DONE | o_done pulse, result held in r_fp
module smag2fp
  import smag2fp_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst,
  smag2fp_if.slave  s_if
);
  state_t              r_state, w_state_nxt;
  logic                r_sign, w_sign_nxt;
  logic [EXP_W-1:0]    r_exp, w_exp_nxt;
  logic [FRAC_W-1:0]   r_frac, w_frac_nxt;
  logic [FP_W-1:0]     r_fp, w_fp_nxt;
  logic                w_zero;
  logic                w_sign_out;

  assign w_zero = (r_frac == '0);

`ifdef SMAG2FP_NEG_ZERO_EN
  assign w_sign_out = r_sign;
`else
  assign w_sign_out = r_sign & ~w_zero;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_sign  <= 1'b0;
      r_exp   <= '0;
      r_frac  <= '0;
      r_fp    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sign  <= w_sign_nxt;
      r_exp   <= w_exp_nxt;
      r_frac  <= w_frac_nxt;
      r_fp    <= w_fp_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sign_nxt  = r_sign;
    w_exp_nxt   = r_exp;
    w_frac_nxt  = r_frac;
    w_fp_nxt    = r_fp;
    case (r_state)
      S_IDLE: begin
        if (s_if.i_start) begin
          w_sign_nxt  = s_if.i_smag[MAG_W];
          w_frac_nxt  = {s_if.i_smag[MAG_W-1:0], 1'b0};
          w_exp_nxt   = EXP_W'(MAG_W);
          w_state_nxt = S_NORM;
        end
      end
      S_NORM: begin
        // Zero magnitude terminates immediately with exp forced to 0.
        if (r_frac[FRAC_W-1] || w_zero) begin
          w_fp_nxt    = pack_fp(w_sign_out, w_zero ? '0 : r_exp, r_frac);
          w_state_nxt = S_DONE;
        end else begin
          w_frac_nxt = {r_frac[FRAC_W-2:0], 1'b0};
          w_exp_nxt  = r_exp - 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign s_if.o_ready = (r_state == S_IDLE);
  assign s_if.o_done  = (r_state == S_DONE);
  assign s_if.o_fp    = r_fp;
endmodule
